// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline-register observations in, forwarding/stall/flush controls out
//   master: pipeline side (drives register fields, enables, memory status; receives controls)
//   slave : hazard_control_unit (observes pipeline, drives Forward*/Stall*/Flush*/halted)
interface hazard_control_unit_if;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeRegE, writeRegM, writeRegW;
    logic       wbEnableE, wbEnableM, wbEnableW;
    logic       memReadE, memReadM, memWriteM, dmem_ready;
    logic       branchTakenE, isJumpD;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE;
    logic       halted;

    modport master (
        output rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
               wbEnableE, wbEnableM, wbEnableW, memReadE, memReadM, memWriteM,
               dmem_ready, branchTakenE, isJumpD,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, halted
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
               wbEnableE, wbEnableM, wbEnableW, memReadE, memReadM, memWriteM,
               dmem_ready, branchTakenE, isJumpD,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, halted
    );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: forwarding selects, per-stage stall/flush and dmem wait watchdog
//   clock, reset_n : rising-edge clock, synchronous active-low reset
//   hz (slave)     : pipeline observations in; Forward*/Stall*/Flush*/halted out
//   HAZARD_PERF_CNT_EN defined: adds loaduse_cnt, memwait_cnt, flush_cnt event counters
module hazard_control_unit #(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    hazard_control_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          loaduse_cnt,
    output logic [31:0]          memwait_cnt,
    output logic [31:0]          flush_cnt
`endif
);
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
    logic              halted_nx;
    logic              mem_busy, load_use, halt_now, quiet, rule_br, rule_lu;

    function automatic logic [1:0] fwd(input logic [4:0] src, input logic wb_m, input logic [4:0] reg_m,
                                       input logic wb_w, input logic [4:0] reg_w);
        return (wb_m && reg_m != 5'd0 && reg_m == src) ? 2'b10 :
               (wb_w && reg_w != 5'd0 && reg_w == src) ? 2'b01 : 2'b00;
    endfunction

    assign mem_busy = (hz.memReadM | hz.memWriteM) & ~hz.dmem_ready;
    assign load_use = hz.memReadE && hz.wbEnableE && hz.writeRegE != 5'd0 &&
                      (hz.writeRegE == hz.rsD || hz.writeRegE == hz.rtD);
    assign halt_now = state == S_HALT;
    // quiet: neither HALT nor a memory wait owns the pipeline this cycle
    assign quiet    = !halt_now && !mem_busy;
    assign rule_br  = quiet && hz.branchTakenE;
    assign rule_lu  = quiet && !hz.branchTakenE && load_use;

    assign hz.ForwardAE = reset_n ? fwd(hz.rsE, hz.wbEnableM, hz.writeRegM, hz.wbEnableW, hz.writeRegW) : 2'b00;
    assign hz.ForwardBE = reset_n ? fwd(hz.rtE, hz.wbEnableM, hz.writeRegM, hz.wbEnableW, hz.writeRegW) : 2'b00;
    assign hz.StallF    = reset_n && (!quiet || rule_lu);
    assign hz.StallD    = reset_n && (!quiet || rule_lu);
    assign hz.StallE    = reset_n && !quiet;
    assign hz.StallM    = reset_n && !quiet;
    // a load-use stall holds the jump in D, so its flush waits until release
    assign hz.FlushD    = !reset_n || rule_br || (quiet && !hz.branchTakenE && !load_use && hz.isJumpD);
    assign hz.FlushE    = !reset_n || rule_br || rule_lu;

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        halted_nx   = hz.halted;
        case (state)
            S_RUN: if (mem_busy) begin
                state_nx    = S_WAIT;
                wait_cnt_nx = WAIT_W'(1);
            end
            S_WAIT: if (!mem_busy) begin
                state_nx    = S_RUN;
                wait_cnt_nx = '0;
            end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                state_nx  = S_HALT;
                halted_nx = 1'b1;
            end else if (wait_cnt != '1) begin
                wait_cnt_nx = wait_cnt + WAIT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            hz.halted <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_cnt_nx;
            hz.halted <= halted_nx;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            loaduse_cnt <= '0;
            memwait_cnt <= '0;
            flush_cnt   <= '0;
        end else begin
            loaduse_cnt <= loaduse_cnt + {31'd0, rule_lu};
            memwait_cnt <= memwait_cnt + {31'd0, !halt_now && mem_busy};
            flush_cnt   <= flush_cnt + {31'd0, rule_br};
        end
    end
`endif
endmodule
